// File: rtl/runner_game_core.sv
`default_nettype none
// ============================================================================
// Module   : runner_game_core
// Brief    : Side-scroller engine: game FSM, scrolling obstacle track, jump
//            timing, score and speed ramp. High score kept when the macro
//            RUNNER_HISCORE_EN is defined, otherwise tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module runner_game_core #(
  parameter int unsigned TRACK_LEN   = 16,
  parameter int unsigned SCORE_W     = 32,
  parameter int unsigned BASE_PERIOD = 250000,
  parameter int unsigned PERIOD_STEP = 20000,
  parameter int unsigned MIN_PERIOD  = 50000,
  parameter int unsigned LEVEL_STEPS = 32,
  parameter int unsigned MAX_LEVEL   = 7,
  parameter int unsigned JUMP_STEPS  = 3,
  parameter int unsigned DENSITY     = 64,
  parameter int unsigned MIN_GAP     = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 jump,
  input  logic                 abort,
  input  logic [15:0]          rand_in,
  output logic [1:0]           state,
  output logic                 dino_air,
  output logic [TRACK_LEN-1:0] obstacle_map,
  output logic [2:0]           level,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   hiscore,
  output logic                 game_over,
  output logic                 frame_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int unsigned c_PRESC_W = $clog2(BASE_PERIOD + 1);
  localparam int unsigned c_AIR_W   = $clog2(JUMP_STEPS + 2);
  localparam int unsigned c_GAP_W   = $clog2(MIN_GAP + 2);
  localparam int unsigned c_LVLC_W  = $clog2(LEVEL_STEPS + 1);
  localparam int unsigned c_SPAN    = BASE_PERIOD - MIN_PERIOD;

  state_t               r_state, w_state_next;
  logic [TRACK_LEN-1:0] r_map, w_map_shift;
  logic [SCORE_W-1:0]   r_score, w_score_next;
  logic [2:0]           r_level;
  logic [c_LVLC_W-1:0]  r_lvl_cnt;
  logic [c_AIR_W-1:0]   r_air, w_air_pre, w_air_next;
  logic [c_GAP_W-1:0]   r_gap;
  logic [c_PRESC_W-1:0] r_presc, w_period;
  logic [31:0]          w_dec;
  logic                 w_play, w_clear, w_step, w_jump_ok, w_spawn, w_collide;
  logic                 w_enter_over, w_frame_next;
  logic                 r_game_over, r_frame_valid;
  logic                 w_unused;

  assign w_unused = ^rand_in[15:8];

  always_comb begin
    w_dec    = 32'(r_level) * PERIOD_STEP;
    w_period = (w_dec > c_SPAN) ? c_PRESC_W'(MIN_PERIOD) : c_PRESC_W'(BASE_PERIOD - w_dec);

    w_play    = (r_state == S_PLAY);
    w_clear   = start && !w_play;
    w_step    = w_play && !abort && (r_presc == w_period - c_PRESC_W'(1));
    // A jump landing on the step cycle is loaded before the step decrements it
    w_jump_ok = w_play && !abort && jump && (r_air == '0);
    w_air_pre = w_jump_ok ? c_AIR_W'(JUMP_STEPS) : r_air;
    w_air_next = (w_step && (w_air_pre != '0)) ? w_air_pre - c_AIR_W'(1) : w_air_pre;

    w_spawn     = ({1'b0, rand_in[7:0]} < 9'(DENSITY)) && (r_gap >= c_GAP_W'(MIN_GAP));
    w_map_shift = {w_spawn, r_map[TRACK_LEN-1:1]};
    w_score_next = r_score;
    if (w_step && (r_score != '1)) begin
      w_score_next = r_score + SCORE_W'(1);
    end
    w_collide = w_step && w_map_shift[0] && (w_air_next == '0);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_PLAY;
      S_PLAY:  if (abort || w_collide) w_state_next = S_OVER;
      S_OVER:  if (start) w_state_next = S_PLAY;
      default: w_state_next = S_IDLE;
    endcase
    w_enter_over = (w_state_next == S_OVER) && (r_state != S_OVER);
    w_frame_next = (w_state_next != r_state) || w_step || w_jump_ok;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_map         <= '0;
      r_score       <= '0;
      r_level       <= '0;
      r_lvl_cnt     <= '0;
      r_air         <= '0;
      r_gap         <= '0;
      r_presc       <= '0;
      r_game_over   <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_game_over   <= w_enter_over;
      r_frame_valid <= w_frame_next;
      if (w_clear) begin
        r_map     <= '0;
        r_score   <= '0;
        r_level   <= '0;
        r_lvl_cnt <= '0;
        r_air     <= '0;
        r_presc   <= '0;
      end else if (w_play && !abort) begin
        r_air <= w_air_next;
        if (w_step) begin
          r_presc <= '0;
          r_map   <= w_map_shift;
          r_score <= w_score_next;
          r_gap   <= w_spawn ? '0 :
                     (r_gap >= c_GAP_W'(MIN_GAP)) ? r_gap : r_gap + c_GAP_W'(1);
          // Level tracks score multiples via a wrap counter instead of a divider
          if (r_score != '1) begin
            if (r_lvl_cnt == c_LVLC_W'(LEVEL_STEPS - 1)) begin
              r_lvl_cnt <= '0;
              if (r_level < 3'(MAX_LEVEL)) r_level <= r_level + 3'd1;
            end else begin
              r_lvl_cnt <= r_lvl_cnt + c_LVLC_W'(1);
            end
          end
        end else begin
          r_presc <= r_presc + c_PRESC_W'(1);
        end
      end
    end
  end

`ifdef RUNNER_HISCORE_EN
  logic [SCORE_W-1:0] r_hiscore;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hiscore <= '0;
    end else if (w_enter_over && (w_score_next > r_hiscore)) begin
      r_hiscore <= w_score_next;
    end
  end

  assign hiscore = r_hiscore;
`else
  assign hiscore = '0;
`endif

  assign state        = r_state;
  assign dino_air     = (r_air != '0);
  assign obstacle_map = r_map;
  assign level        = r_level;
  assign score        = r_score;
  assign game_over    = r_game_over;
  assign frame_valid  = r_frame_valid;

endmodule

`default_nettype wire

// File: tb/tb_runner_game_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_runner_game_core
// Brief    : Directed and random scenarios against an obstacle-list game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_runner_game_core;

  localparam int TL = 16, SW = 32, BP = 16, PS = 2, MP = 4, LS = 32, ML = 7;
  localparam int JS = 3, DEN = 64, MG = 2;
`ifdef RUNNER_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic          CLK = 1'b0, RST = 1'b0, start = 1'b0, jump = 1'b0, abort = 1'b0;
  logic [15:0]   rand_in = 16'h0;
  logic [1:0]    state;
  logic          dino_air, game_over, frame_valid;
  logic [TL-1:0] obstacle_map;
  logic [2:0]    level;
  logic [SW-1:0] score, hiscore;
  logic [87:0]   dut_vec;
  int            total = 0, bad = 0;

  runner_game_core #(
    .TRACK_LEN(TL), .SCORE_W(SW), .BASE_PERIOD(BP), .PERIOD_STEP(PS), .MIN_PERIOD(MP),
    .LEVEL_STEPS(LS), .MAX_LEVEL(ML), .JUMP_STEPS(JS), .DENSITY(DEN), .MIN_GAP(MG)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .jump(jump), .abort(abort), .rand_in(rand_in),
    .state(state), .dino_air(dino_air), .obstacle_map(obstacle_map), .level(level),
    .score(score), .hiscore(hiscore), .game_over(game_over), .frame_valid(frame_valid)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {state, dino_air, obstacle_map, level, score, hiscore, game_over, frame_valid};

  // Game model: obstacles are a list of column positions, level derived from score
  int     m_state = 0, m_air = 0, m_gap = 0, m_since = 0;
  int     m_obs[$];
  longint m_score = 0, m_hi = 0;
  bit     m_fv = 0, m_go = 0;

  function automatic int m_level();
    longint q = m_score / LS;
    return (q > ML) ? ML : int'(q);
  endfunction

  function automatic int m_period();
    int p = BP - m_level() * PS;
    return (p < MP) ? MP : p;
  endfunction

  function automatic logic [TL-1:0] m_map();
    logic [TL-1:0] v = '0;
    foreach (m_obs[i]) v[m_obs[i]] = 1'b1;
    return v;
  endfunction

  function automatic logic [87:0] exp_vec();
    return {2'(m_state), (m_air != 0), m_map(), 3'(m_level()), SW'(m_score), SW'(m_hi), m_go, m_fv};
  endfunction

  task automatic model_reset();
    m_state = 0; m_obs = {}; m_score = 0; m_air = 0; m_gap = 0; m_since = 0;
    m_hi = 0; m_fv = 0; m_go = 0;
  endtask

  task automatic model_tick(input bit st, input bit jp, input bit ab, input logic [15:0] rnd);
    int  old = m_state;
    bit  stepped = 0, jumped = 0, hit = 0;
    int  nq[$];
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_obs = {}; m_score = 0; m_air = 0; m_since = 0;
      end
    end else if (ab) begin
      m_state = 2;
    end else begin
      if (jp && m_air == 0) begin m_air = JS; jumped = 1; end
      if (m_since == m_period() - 1) begin
        stepped = 1; m_since = 0;
        foreach (m_obs[i]) if (m_obs[i] > 0) nq.push_back(m_obs[i] - 1);
        m_obs = nq;
        if (int'(rnd[7:0]) < DEN && m_gap >= MG) begin m_obs.push_back(TL - 1); m_gap = 0; end
        else if (m_gap < MG) m_gap++;
        m_score++;
        if (m_air > 0) m_air--;
        foreach (m_obs[i]) if (m_obs[i] == 0) hit = 1;
        if (hit && m_air == 0) m_state = 2;
      end else begin
        m_since++;
      end
    end
    m_go = (m_state == 2) && (old != 2);
    m_fv = stepped || jumped || (m_state != old);
    if (m_go && HI_EN && m_score > m_hi) m_hi = m_score;
  endtask

  task automatic tick(input bit st, input bit jp, input bit ab, input logic [15:0] rnd);
    start = st; jump = jp; abort = ab; rand_in = rnd;
    model_tick(st, jp, ab, rnd);
    @(posedge CLK); #1;
    start = 0; jump = 0; abort = 0;
  endtask

  task automatic do_reset();
    start = 0; jump = 0; abort = 0; RST = 1; model_reset();
    @(posedge CLK); #1;
    RST = 0;
  endtask

  task automatic test_reset();
    start = 1; jump = 1; abort = 1;
    #3 RST = 1; #1;
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL reset_async got=%h want=0", dut_vec); end
    model_reset();
    repeat (2) @(posedge CLK); #1;
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL reset_hold got=%h want=0", dut_vec); end
    start = 0; jump = 0; abort = 0; RST = 0;
    tick(0, 1, 1, 16'h0);
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL idle_ignore got=%h want=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_no_spawn();
    int n = 0; bit go_seen = 0;
    tick(1, 0, 0, 16'hFFFF);
    total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t1_start got=%h want=%h", dut_vec, exp_vec()); end
    while (m_score < 40 && n < 2000) begin
      tick(0, 0, 0, 16'hFFFF); n++;
      if (game_over) go_seen = 1;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t1_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    total++; if (score !== 40) begin bad++; $display("FAIL t1_score got=%0d want=40", score); end
    total++; if (obstacle_map !== '0) begin bad++; $display("FAIL t1_map got=%h want=0", obstacle_map); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL t1_level got=%0d want=1", level); end
    total++; if (go_seen || state !== 2'd1) begin bad++; $display("FAIL t1_alive go=%0b state=%0d want go=0 state=1", go_seen, state); end
  endtask

  task automatic test_spawn();
    int n = 0;
    do_reset();
    tick(1, 0, 0, 16'h0000);
    while (m_score < 9 && n < 400) begin
      tick(0, 0, 0, 16'h0000); n++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t2_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    total++; if (obstacle_map !== 16'h9200) begin bad++; $display("FAIL t2_pattern got=%h want=9200", obstacle_map); end
  endtask

  task automatic test_collision();
    int n = 0, go_cnt;
    while (m_state == 1 && n < 1000) begin
      tick(0, 0, 0, 16'hFFFF); n++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t3_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    total++; if (state !== 2'd2 || score !== 18 || obstacle_map[0] !== 1'b1)
      begin bad++; $display("FAIL t3_hit state=%0d score=%0d map0=%0b want 2/18/1", state, score, obstacle_map[0]); end
    go_cnt = int'(game_over);
    repeat (4) begin
      tick(0, 1, 1, 16'h0);
      go_cnt += int'(game_over);
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t3_frozen t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    total++; if (go_cnt != 1) begin bad++; $display("FAIL t3_go_pulse got=%0d want=1", go_cnt); end
  endtask

  task automatic test_jump();
    int n = 0; longint s;
    do_reset();
    tick(1, 0, 0, 16'h0000);
    while (m_obs.size() == 0 && n < 200) begin tick(0, 0, 0, 16'h0000); n++; end
    while ((m_obs.size() == 0 || m_obs[0] != 1) && n < 600) begin
      tick(0, 0, 0, 16'hFFFF); n++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t4_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    tick(0, 1, 0, 16'hFFFF);
    total++; if (dino_air !== 1'b1) begin bad++; $display("FAIL t4_takeoff got=%0b want=1", dino_air); end
    s = m_score; n = 0;
    while (m_score < s + 1 && n < 100) begin tick(0, 0, 0, 16'hFFFF); n++; end
    total++; if (state !== 2'd1 || obstacle_map[0] !== 1'b1 || dino_air !== 1'b1)
      begin bad++; $display("FAIL t4_clear state=%0d map0=%0b air=%0b want 1/1/1", state, obstacle_map[0], dino_air); end
    tick(0, 1, 0, 16'hFFFF);
    n = 0;
    while (m_score < s + 3 && n < 100) begin
      tick(0, 0, 0, 16'hFFFF); n++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t4_lockstep2 t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    total++; if (dino_air !== 1'b0 || state !== 2'd1) begin bad++; $display("FAIL t4_land air=%0b state=%0d want 0/1", dino_air, state); end
  endtask

  task automatic test_abort();
    int n = 0; longint s;
    while (m_since != m_period() - 1 && n < 100) begin tick(0, 0, 0, 16'hFFFF); n++; end
    s = m_score;
    tick(0, 0, 1, 16'hFFFF);
    total++; if (state !== 2'd2 || game_over !== 1'b1 || score !== SW'(s))
      begin bad++; $display("FAIL t5_abort state=%0d go=%0b score=%0d want 2/1/%0d", state, game_over, score, s); end
    total++; if (hiscore !== (HI_EN ? SW'(s) : '0)) begin bad++; $display("FAIL t5_hi_over got=%0d want=%0d", hiscore, HI_EN ? s : 0); end
    tick(1, 0, 0, 16'hFFFF);
    total++; if (state !== 2'd1 || score !== '0 || hiscore !== (HI_EN ? SW'(s) : '0))
      begin bad++; $display("FAIL t5_restart state=%0d score=%0d hi=%0d", state, score, hiscore); end
  endtask

  task automatic test_level_period();
    int n = 0;
    do begin tick(0, 0, 0, 16'hFFFF); n++; end while (!frame_valid && n < 64);
    total++; if (n != BP) begin bad++; $display("FAIL t6_period0 got=%0d want=%0d", n, BP); end
    n = 0;
    while (m_level() < ML && n < 4000) begin
      tick(0, 0, 0, 16'hFFFF); n++;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL t6_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
    n = 0;
    do begin tick(0, 0, 0, 16'hFFFF); n++; end while (!frame_valid && n < 64);
    total++; if (n != MP || level !== 3'(ML)) begin bad++; $display("FAIL t6_period7 got=%0d lvl=%0d want=%0d lvl=%0d", n, level, MP, ML); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    tick(1, 0, 0, 16'hFFFF);
    while (m_score < 17 && n < 1000) begin tick(0, 0, 0, 16'hFFFF); n++; end
    total++; if (score !== 17) begin bad++; $display("FAIL t6_pre got=%0d want=17", score); end
    #2 RST = 1; #1;
    total++; if (dut_vec !== '0) begin bad++; $display("FAIL t6_async got=%h want=0", dut_vec); end
    model_reset();
    @(posedge CLK); #1; RST = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0, 16'($urandom));
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rand_lockstep t=%0t got=%h want=%h", $time, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_no_spawn();
    test_spawn();
    test_collision();
    test_jump();
    test_abort();
    test_level_period();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
